// File: rtl/rtc_access_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_access_scheduler_pkg
//  Description : Shared definitions for the RTC access scheduler: FSM state
//                encoding, RTC time-register base address and the default
//                timing parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
package rtc_access_scheduler_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_GAP       = 2'd3;

  // First time register; refresh reads RTC_BASE_ADDR .. RTC_BASE_ADDR+N_READ-1
  localparam logic [7:0] RTC_BASE_ADDR = 8'h21;

  // Parameter defaults
  localparam int GAP_CYCLES_DEF = 4;
  localparam int TIMEOUT_DEF    = 31;
  localparam int N_READ_DEF     = 6;

endpackage : rtc_access_scheduler_pkg
`default_nettype wire

// File: rtl/rtc_access_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : rtc_access_scheduler
//  Description : Sequences register accesses to an external RTC signal
//                generator. A refresh reads N_READ time registers into
//                time_regs; a write sends one byte to one register. Writes
//                take priority over refreshes. Each transaction is a one-cycle
//                gen_en, a wait for gen_done (bounded by TIMEOUT) and an idle
//                gap of GAP_CYCLES.
//  Ports       : clk, reset_count (async, active-high)
//                req_refresh, req_write, wr_addr, wr_data   - requests
//                gen_done, gen_dir_data, bus_in              - from generator
//                gen_en, gen_wr, bus_out, bus_oe             - to generator/bus
//                time_regs, busy, done, err_timeout, wr_overrun - status
//  Revision    : 1.0 - initial release
// ============================================================================
module rtc_access_scheduler
  import rtc_access_scheduler_pkg::*;
#(
  parameter int GAP_CYCLES = GAP_CYCLES_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int N_READ     = N_READ_DEF
) (
  input  logic              clk,
  input  logic              reset_count,
  input  logic              req_refresh,
  input  logic              req_write,
  input  logic [7:0]        wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              gen_done,
  input  logic              gen_dir_data,
  input  logic [7:0]        bus_in,
  output logic              gen_en,
  output logic              gen_wr,
  output logic [7:0]        bus_out,
  output logic              bus_oe,
  output logic [8*N_READ-1:0] time_regs,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              wr_overrun
);

  localparam int KW      = (N_READ > 1) ? $clog2(N_READ) : 1;
  localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [1:0]          state_q,    state_d;
  logic                pend_wr_q,  pend_wr_d;
  logic                pend_rf_q,  pend_rf_d;
  logic [7:0]          wr_addr_q,  wr_addr_d;
  logic [7:0]          wr_data_q,  wr_data_d;
  logic [7:0]          cur_addr_q, cur_addr_d;   // write copy frozen for the active sequence
  logic [7:0]          cur_data_q, cur_data_d;
  logic                is_wr_q,    is_wr_d;
  logic [KW-1:0]       k_q,        k_d;
  logic [CW-1:0]       cnt_q,      cnt_d;
  logic [8*N_READ-1:0] time_regs_q, time_regs_d;
  logic                err_q,      err_d;

  logic clr_wr, clr_rf, last_txn, seq_done, in_xfer, accept_wr;
  logic [7:0] cur_txn_addr;

  assign last_txn     = is_wr_q || (k_q == KW'(N_READ - 1));
  assign in_xfer      = (state_q == ST_ISSUE) || (state_q == ST_WAIT_DONE);
  assign cur_txn_addr = is_wr_q ? cur_addr_q : (RTC_BASE_ADDR + 8'(k_q));

  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    cur_addr_d  = cur_addr_q;
    cur_data_d  = cur_data_q;
    time_regs_d = time_regs_q;
    clr_wr      = 1'b0;
    clr_rf      = 1'b0;
    seq_done    = 1'b0;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        k_d = '0;
        if (pend_wr_q) begin
          state_d    = ST_ISSUE;
          is_wr_d    = 1'b1;
          cur_addr_d = wr_addr_q;
          cur_data_d = wr_data_q;
          clr_wr     = 1'b1;
        end else if (pend_rf_q) begin
          state_d = ST_ISSUE;
          is_wr_d = 1'b0;
          clr_rf  = 1'b1;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_DONE;
        cnt_d   = '0;
      end
      ST_WAIT_DONE: begin
        if (gen_done) begin
          if (!is_wr_q) time_regs_d[8*int'(k_q) +: 8] = bus_in;
          state_d = ST_GAP;
          cnt_d   = '0;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Abort: the sequence and any re-queued request of its kind are dropped
          err_d   = 1'b1;
          state_d = ST_IDLE;
          clr_wr  = is_wr_q;
          clr_rf  = !is_wr_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin // ST_GAP
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          if (last_txn) begin
            state_d  = ST_IDLE;
            seq_done = 1'b1;
          end else begin
            state_d = ST_ISSUE;
            k_d     = k_q + KW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase

    // A flag clearing this cycle can be re-set by a request in the same cycle
    wr_overrun = req_write && pend_wr_q && !clr_wr;
    accept_wr  = req_write && !wr_overrun;

    pend_wr_d = (pend_wr_q && !clr_wr) || accept_wr;
    pend_rf_d = (pend_rf_q && !clr_rf) || req_refresh;
    wr_addr_d = accept_wr ? wr_addr : wr_addr_q;
    wr_data_d = accept_wr ? wr_data : wr_data_q;

    if (!(state_q == ST_WAIT_DONE && state_d == ST_IDLE) && (accept_wr || req_refresh))
      err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count) begin
      state_q     <= ST_IDLE;
      pend_wr_q   <= 1'b0;
      pend_rf_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cur_addr_q  <= '0;
      cur_data_q  <= '0;
      is_wr_q     <= 1'b0;
      k_q         <= '0;
      cnt_q       <= '0;
      time_regs_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_wr_q   <= pend_wr_d;
      pend_rf_q   <= pend_rf_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cur_addr_q  <= cur_addr_d;
      cur_data_q  <= cur_data_d;
      is_wr_q     <= is_wr_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      time_regs_q <= time_regs_d;
      err_q       <= err_d;
    end
  end

  // Outputs decode from state, so they all sit at zero while reset holds IDLE
  always_comb begin
    gen_en  = (state_q == ST_ISSUE);
    gen_wr  = in_xfer && is_wr_q;
    bus_oe  = in_xfer && !(gen_dir_data && !is_wr_q);
    bus_out = 8'h00;
    if (in_xfer) begin
      if (!gen_dir_data)  bus_out = cur_txn_addr;
      else if (is_wr_q)   bus_out = cur_data_q;
    end
  end

  assign time_regs   = time_regs_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = seq_done;
  assign err_timeout = err_q;

endmodule : rtc_access_scheduler
`default_nettype wire
